// File: rtl/video_frame_controller_pkg.sv
// Shared VGA timing constants and register map for the video frame controller.
// Optional vertical-blank interrupt enabled by defining VIDEO_VBLANK_IRQ_EN.
package video_pkg;

    localparam int H_VISIBLE_C = 640;
    localparam int H_FRONT_C   = 16;
    localparam int H_SYNC_C    = 96;
    localparam int H_BACK_C    = 48;
    localparam int V_VISIBLE_C = 480;
    localparam int V_FRONT_C   = 10;
    localparam int V_SYNC_C    = 2;
    localparam int V_BACK_C    = 33;

    localparam int H_TOTAL_C =
        H_VISIBLE_C + H_FRONT_C + H_SYNC_C + H_BACK_C;
    localparam int V_TOTAL_C =
        V_VISIBLE_C + V_FRONT_C + V_SYNC_C + V_BACK_C;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;

    localparam int REG_ADDR_W = 2;

    localparam logic [1:0] REG_FRAME   = 2'd0;
    localparam logic [1:0] REG_CONTROL = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_FCOUNT  = 2'd3;

endpackage

// File: rtl/video_frame_controller_if.sv
// CPU peripheral register bus of the video frame controller.
// master = CPU side, slave = controller side.
interface video_frame_controller_if;
    import video_pkg::*;

    logic                  reg_write_enable;
    logic                  reg_read_enable;
    logic [REG_ADDR_W-1:0] reg_address;
    logic [31:0]           reg_write_data;
    logic [31:0]           reg_read_data;

    modport master (
        output reg_write_enable,
        output reg_read_enable,
        output reg_address,
        output reg_write_data,
        input  reg_read_data
    );

    modport slave (
        input  reg_write_enable,
        input  reg_read_enable,
        input  reg_address,
        input  reg_write_data,
        output reg_read_data
    );

endinterface

// File: rtl/video_frame_controller_timing.sv
// Pixel divider, h/v counters and one-pixel-delayed sync/active outputs.
// Also exposes next counter values and the vblank-start pulse.
module video_timing_generator
    import video_pkg::*;
#(
    parameter int CLOCK_DIVIDER = 2,
    parameter int H_VISIBLE     = H_VISIBLE_C,
    parameter int H_FRONT       = H_FRONT_C,
    parameter int H_SYNC        = H_SYNC_C,
    parameter int H_BACK        = H_BACK_C,
    parameter int V_VISIBLE     = V_VISIBLE_C,
    parameter int V_FRONT       = V_FRONT_C,
    parameter int V_SYNC        = V_SYNC_C,
    parameter int V_BACK        = V_BACK_C
) (
    input  logic       clock,
    input  logic       reset,
    output logic       o_tick,
    output logic       o_vblank_start,
    output logic [9:0] o_h,
    output logic [9:0] o_v,
    output logic [9:0] o_h_next,
    output logic [9:0] o_v_next,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_active
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_LO   = H_VISIBLE + H_FRONT;
    localparam int HS_HI   = HS_LO + H_SYNC - 1;
    localparam int VS_LO   = V_VISIBLE + V_FRONT;
    localparam int VS_HI   = VS_LO + V_SYNC - 1;
    localparam int DW      = $clog2(CLOCK_DIVIDER);

    logic [DW-1:0] r_div;
    logic [9:0]    r_h;
    logic [9:0]    r_v;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_active;
    logic          w_tick;
    logic          w_h_last;
    logic          w_v_last;
    logic [9:0]    w_h_next;
    logic [9:0]    w_v_next;

    assign w_tick   = (r_div == DW'(CLOCK_DIVIDER - 1));
    assign w_h_last = (r_h == 10'(H_TOTAL - 1));
    assign w_v_last = (r_v == 10'(V_TOTAL - 1));

    always_comb begin
        w_h_next = r_h + 10'd1;
        w_v_next = r_v;
        if (w_h_last) begin
            w_h_next = '0;
            w_v_next = w_v_last ? '0 : r_v + 10'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Sync/active sampled from the pre-advance counts: one pixel late.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_h      <= '0;
            r_v      <= '0;
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
            r_active <= 1'b0;
        end else if (w_tick) begin
            r_h      <= w_h_next;
            r_v      <= w_v_next;
            r_hsync  <= !((r_h >= 10'(HS_LO)) && (r_h <= 10'(HS_HI)));
            r_vsync  <= !((r_v >= 10'(VS_LO)) && (r_v <= 10'(VS_HI)));
            r_active <= (r_h < 10'(H_VISIBLE)) && (r_v < 10'(V_VISIBLE));
        end
    end

    assign o_tick         = w_tick;
    assign o_vblank_start = w_tick && w_h_last &&
                            (r_v == 10'(V_VISIBLE - 1));
    assign o_h            = r_h;
    assign o_v            = r_v;
    assign o_h_next       = w_h_next;
    assign o_v_next       = w_v_next;
    assign o_hsync        = r_hsync;
    assign o_vsync        = r_vsync;
    assign o_active       = r_active;

endmodule

// File: rtl/video_frame_controller.sv
// Video frame controller: VGA timing, frame-buffer addressing, CPU registers.
// Define VIDEO_VBLANK_IRQ_EN to build the vertical-blank interrupt.
module video_frame_controller
    import video_pkg::*;
#(
    parameter int CLOCK_DIVIDER = 2,
    parameter int H_VISIBLE     = H_VISIBLE_C,
    parameter int H_FRONT       = H_FRONT_C,
    parameter int H_SYNC        = H_SYNC_C,
    parameter int H_BACK        = H_BACK_C,
    parameter int V_VISIBLE     = V_VISIBLE_C,
    parameter int V_FRONT       = V_FRONT_C,
    parameter int V_SYNC        = V_SYNC_C,
    parameter int V_BACK        = V_BACK_C
) (
    input  logic                           clock,
    input  logic                           reset,
    video_frame_controller_if.slave        bus,
    output logic [9:0]                     pixel_x_pos,
    output logic [9:0]                     pixel_y_pos,
    output logic [16:0]                    fb_address,
    output logic                           frame_select_memory,
    output logic                           osd_display,
    output logic                           video_hsync,
    output logic                           video_vsync,
    output logic                           video_active,
    output logic                           vblank_irq
);
    localparam int FB_STRIDE = H_VISIBLE / 2;

    logic        w_tick;
    logic        w_vblank_start;
    logic [9:0]  w_h;
    logic [9:0]  w_v;
    logic [9:0]  w_h_next;
    logic [9:0]  w_v_next;
    logic [16:0] w_fb_next;
    logic        w_wr_frame;
    logic        w_wr_ctrl;
    logic        w_wr_status;
    logic        w_in_vblank;
    logic        w_irq_en;
    logic        w_irq_flag;
    logic [31:0] w_rdata;
    logic        w_unused;

    logic [16:0] r_fb;
    logic        r_active_frame;
    logic        r_req_frame;
    logic        r_pending;
    logic        r_osd;
    logic [31:0] r_fcount;

    video_timing_generator #(
        .CLOCK_DIVIDER (CLOCK_DIVIDER),
        .H_VISIBLE     (H_VISIBLE),
        .H_FRONT       (H_FRONT),
        .H_SYNC        (H_SYNC),
        .H_BACK        (H_BACK),
        .V_VISIBLE     (V_VISIBLE),
        .V_FRONT       (V_FRONT),
        .V_SYNC        (V_SYNC),
        .V_BACK        (V_BACK)
    ) u_timing (
        .clock          (clock),
        .reset          (reset),
        .o_tick         (w_tick),
        .o_vblank_start (w_vblank_start),
        .o_h            (w_h),
        .o_v            (w_v),
        .o_h_next       (w_h_next),
        .o_v_next       (w_v_next),
        .o_hsync        (video_hsync),
        .o_vsync        (video_vsync),
        .o_active       (video_active)
    );

    assign w_wr_frame  = bus.reg_write_enable && (bus.reg_address == REG_FRAME);
    assign w_wr_ctrl   = bus.reg_write_enable && (bus.reg_address == REG_CONTROL);
    assign w_wr_status = bus.reg_write_enable && (bus.reg_address == REG_STATUS);
    assign w_in_vblank = (w_v >= 10'(V_VISIBLE));

    // Address tracks the counters so it names the pixel on pixel_x/y_pos.
    always_comb begin
        w_fb_next = '0;
        if ((w_h_next < 10'(H_VISIBLE)) && (w_v_next < 10'(V_VISIBLE))) begin
            w_fb_next = 17'(w_v_next >> 1) * 17'(FB_STRIDE)
                      + 17'(w_h_next >> 1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fb <= '0;
        end else if (w_tick) begin
            r_fb <= w_fb_next;
        end
    end

    // A FRAME write colliding with vblank start stays pending for next frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_active_frame <= 1'b0;
            r_req_frame    <= 1'b0;
            r_pending      <= 1'b0;
            r_osd          <= 1'b0;
            r_fcount       <= '0;
        end else begin
            if (w_vblank_start) begin
                r_active_frame <= r_req_frame;
                r_pending      <= 1'b0;
                r_fcount       <= r_fcount + 32'd1;
            end
            if (w_wr_frame) begin
                r_req_frame <= bus.reg_write_data[0];
                r_pending   <= 1'b1;
            end
            if (w_wr_ctrl) begin
                r_osd <= bus.reg_write_data[0];
            end
        end
    end

`ifdef VIDEO_VBLANK_IRQ_EN
    logic r_irq_en;
    logic r_irq_flag;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_irq_en   <= 1'b0;
            r_irq_flag <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_irq_en <= bus.reg_write_data[1];
            end
            if (w_vblank_start) begin
                r_irq_flag <= 1'b1;
            end else if (w_wr_status && bus.reg_write_data[2]) begin
                r_irq_flag <= 1'b0;
            end
        end
    end

    assign w_irq_en   = r_irq_en;
    assign w_irq_flag = r_irq_flag;
`else
    assign w_irq_en   = 1'b0;
    assign w_irq_flag = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        unique case (bus.reg_address)
            REG_FRAME:   w_rdata = {30'b0, r_active_frame, r_req_frame};
            REG_CONTROL: w_rdata = {30'b0, w_irq_en, r_osd};
            REG_STATUS:  w_rdata = {29'b0, w_irq_flag, r_pending, w_in_vblank};
            REG_FCOUNT:  w_rdata = r_fcount;
            default:     w_rdata = '0;
        endcase
    end

    assign w_unused = ^{bus.reg_read_enable, bus.reg_write_data};

    assign bus.reg_read_data   = w_rdata;
    assign pixel_x_pos         = w_h;
    assign pixel_y_pos         = w_v;
    assign fb_address          = r_fb;
    assign frame_select_memory = r_active_frame;
    assign osd_display         = r_osd;
    assign vblank_irq          = w_irq_en & w_irq_flag;

endmodule

// File: doc/video_frame_controller.md
Name: video_frame_controller

Overview:
- Sequences the video compositor and owns its configuration.
- Generates 640x480@60 VGA timing and the pixel_x_pos/pixel_y_pos stream that the compositor consumes.
- Issues frame-buffer read addresses and exposes a small CPU register file: frame select (double-buffered, swapped only in vertical blanking), OSD enable, status and frame counter.
- Sits between the CPU peripheral bus, both frame-buffer RAMs and video_compositor.

Parameters:
- CLOCK_DIVIDER, 2: core clocks per pixel; must be ≥2.
- H_VISIBLE, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch.
- H_SYNC, 96: horizontal sync width.
- H_BACK, 48: horizontal back porch.
- V_VISIBLE, 480: visible lines.
- V_FRONT, 10: vertical front porch.
- V_SYNC, 2: vertical sync width.
- V_BACK, 33: vertical back porch.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- reg_write_enable  in  1  CPU register write strobe (one clock)
- reg_read_enable  in  1  CPU register read strobe
- reg_address  in  2  register index
- reg_write_data  in  32  write data
- reg_read_data  out  32  read data, combinational from reg_address
- pixel_x_pos  out  10  current horizontal counter, to compositor
- pixel_y_pos  out  10  current vertical counter, to compositor
- fb_address  out  17  frame-buffer read address for the current pixel
- frame_select_memory  out  1  active frame, to compositor
- osd_display  out  1  OSD enable, to compositor
- video_hsync  out  1  horizontal sync, active low
- video_vsync  out  1  vertical sync, active low
- video_active  out  1  high in the visible area
- vblank_irq  out  1  vertical-blank interrupt (optional feature)

Behaviour:
- Clock and reset: single clock `clock`; reset is synchronous and active-high.
- Pixel tick:
  - Divider counter runs 0..CLOCK_DIVIDER-1.
  - pixel_tick is high for one clock when the counter = CLOCK_DIVIDER-1.
  - Divider counter resets to 0.
- Counters:
  - h_count advances on pixel_tick and wraps at H_total-1 = 799 to 0.
  - v_count advances when h_count wraps and itself wraps at 524 to 0.
  - pixel_x_pos = h_count; pixel_y_pos = v_count (registered).
- Sync and active:
  - video_hsync is low for h_count in [656,751].
  - video_vsync is low for v_count in [490,491].
  - video_active = (h<640)&&(v<480).
  - Sync/active outputs are delayed one pixel_tick, to align with compositor RGB that uses the synchronous RAM's 1-clock read latency.
- fb_address:
  - fb_address = (v_count>>1)*320 + (h_count>>1) while active; 0 otherwise.
  - Registered; updates in the same clock as the counters.
- Registers:
  - 0 FRAME: write bit0 → requested_frame. Read {30'b0, active_frame, requested_frame}.
  - 1 CONTROL: bit0 osd_display (r/w).
  - 2 STATUS: bit0 in_vblank (v≥480, RO); bit1 swap_pending (RO); bit2 irq_flag (write 1 clears).
  - 3 FRAME_COUNT: 32-bit, increments at each vblank start, wraps at 2^32-1 → 0; writes ignored.
- Frame swap:
  - swap_pending is set when FRAME is written.
  - At vblank start (pixel_tick with h wrapping and v 479→480): active_frame ← requested_frame and swap_pending ← 0.
  - A write in the same clock as vblank start is not applied; it stays pending until the next frame.
- Reads: reg_read_enable has no side effects.
- Reset values:
  - All counters 0; hsync/vsync 1; video_active 0; fb_address 0.
  - active_frame, requested_frame and osd_display 0; swap_pending 0; FRAME_COUNT 0; irq_flag 0; vblank_irq 0.
- Reset mid-frame restarts the timing at (0,0) on the next clock.

Optional Feature:
- VIDEO_VBLANK_IRQ_EN defined:
  - irq_flag is set at vblank start; vblank_irq = irq_flag & CONTROL bit1 (irq enable).
  - Write-1 to STATUS bit2 clears it; a set in the same clock as a clear wins.
- Undefined: vblank_irq tied 0; CONTROL bit1 and STATUS bit2 read 0.

Decomposition:
- Package video_pkg:
  - VGA timing constants and derived totals (800, 525).
  - Register index localparams.
  - FB_WIDTH=320 and FB_HEIGHT=240.
- Sub-module video_timing_generator: divider, h/v counters, sync/active. The controller wraps it and adds the register file, frame swap and address generation.

Test Plan:
- Reset, then run one frame → first hsync low at h=656, 800 pixel_ticks per line, 525 lines per frame, vsync low exactly on lines 490–491.
- At x=639, y=479 → fb_address=76799; at x=640 → video_active=0 and fb_address=0.
- Write FRAME=1 at line 100 → STATUS=0b10, frame_select_memory stays 0 until the v 479→480 transition, then becomes 1 and swap_pending clears.
- Write FRAME in the exact vblank-start clock → active frame unchanged; swap occurs at the next frame's vblank.
- With VIDEO_VBLANK_IRQ_EN and CONTROL=0b10 → vblank_irq rises at vblank start and FRAME_COUNT increments by 1; write STATUS=0b100 → vblank_irq low the next clock.
- Assert reset at mid-frame (x=300, y=200) → next clock counters are 0, outputs at reset values, and FRAME_COUNT=0.
